fir_tdm_param: RTL and testbench

FIR_TDM_PARAM -- requirements
Module: fir_tdm_param

---
 rtl/fir_tdm_param.sv | 159 +++++++++++++++
 tb/tb_fir_tdm_param.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_tdm_param.sv
// fir_tdm_param: time-multiplexed FIR filter with one MAC and a circular
// delay line. Each accepted sample costs TAPS+2 cycles: one accept edge,
// TAPS multiply-accumulate edges and one output edge.
// Optional build macro: FIR_SAT_EN saturates the result to DATA_W bits
// instead of wrapping it.
module fir_tdm_param #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int TAPS   = 57,
  parameter int FRAC   = 14
) (
  input  logic                      clock_50,
  input  logic                      reset,
  input  logic [DATA_W-1:0]         din,
  input  logic                      din_valid,
  output logic                      din_ready,
  output logic [DATA_W-1:0]         dout,
  output logic                      dout_valid,
  input  logic                      coef_we,
  input  logic [$clog2(TAPS)-1:0]   coef_addr,
  input  logic [COEF_W-1:0]         coef_wdata,
  output logic                      busy
);

  localparam int AW     = $clog2(TAPS);
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ACC_W  = DATA_W + COEF_W + AW;

  localparam logic [1:0] ST_CLEAR = 2'd0;
  localparam logic [1:0] ST_IDLE  = 2'd1;
  localparam logic [1:0] ST_MAC   = 2'd2;
  localparam logic [1:0] ST_OUT   = 2'd3;

  localparam logic [AW:0]   TAPS_X = (AW+1)'(TAPS);
  localparam logic [AW-1:0] LAST   = AW'(TAPS - 1);

  logic [1:0]               state;
  logic [AW-1:0]            wptr;
  logic [AW-1:0]            k;
  logic signed [ACC_W-1:0]  acc;
  logic signed [COEF_W-1:0] coef [TAPS];
  logic signed [DATA_W-1:0] dline [TAPS];

  logic                     accept;
  logic                     coef_ok;
  logic [AW-1:0]            wptr_next;
  logic [AW-1:0]            rd_idx;
  logic signed [PROD_W-1:0] c_ext;
  logic signed [PROD_W-1:0] d_ext;
  logic signed [PROD_W-1:0] prod;
  logic [DATA_W-1:0]        out_val;

  assign din_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign accept    = (state == ST_IDLE) && din_valid;
  // Out-of-range addresses never reach the coefficient bank.
  assign coef_ok   = coef_we && (state == ST_IDLE) && ({1'b0, coef_addr} < TAPS_X);
  assign wptr_next = (wptr == LAST) ? '0 : wptr + AW'(1);

  // Tap address (wptr - k) mod TAPS and the full-precision signed product.
  always_comb begin
    rd_idx = '0;
    if (wptr >= k) begin
      rd_idx = wptr - k;
    end else begin
      rd_idx = AW'({1'b0, wptr} + TAPS_X - {1'b0, k});
    end
    c_ext = PROD_W'(coef[k]);
    d_ext = PROD_W'(dline[rd_idx]);
    prod  = c_ext * d_ext;
  end

`ifdef FIR_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;
  logic signed [ACC_W-1:0] shifted;

  // Scale down by FRAC and clamp to the representable output range.
  always_comb begin
    shifted = acc >>> FRAC;
    if (shifted > SAT_MAX) begin
      out_val = SAT_MAX[DATA_W-1:0];
    end else if (shifted < SAT_MIN) begin
      out_val = SAT_MIN[DATA_W-1:0];
    end else begin
      out_val = shifted[DATA_W-1:0];
    end
  end
`else
  // Scale down by FRAC and keep the low DATA_W bits (wrap-around).
  always_comb begin
    out_val = DATA_W'(acc >>> FRAC);
  end
`endif

  // Control FSM, accumulator, output register and coefficient bank.
  always_ff @(posedge clock_50 or posedge reset) begin
    if (reset) begin
      state      <= ST_CLEAR;
      dout       <= '0;
      dout_valid <= 1'b0;
      acc        <= '0;
      wptr       <= '0;
      k          <= '0;
      for (int i = 0; i < TAPS; i++) begin
        coef[i] <= '0;
      end
    end else begin
      dout_valid <= 1'b0;
      // The write lands on the accept edge, so MAC already sees it.
      if (coef_ok) begin
        coef[coef_addr] <= coef_wdata;
      end
      case (state)
        ST_CLEAR: begin
          if (k == LAST) begin
            k     <= '0;
            state <= ST_IDLE;
          end else begin
            k <= k + AW'(1);
          end
        end
        ST_IDLE: begin
          if (din_valid) begin
            wptr  <= wptr_next;
            acc   <= '0;
            k     <= '0;
            state <= ST_MAC;
          end
        end
        ST_MAC: begin
          acc <= acc + ACC_W'(prod);
          if (k == LAST) begin
            k     <= '0;
            state <= ST_OUT;
          end else begin
            k <= k + AW'(1);
          end
        end
        ST_OUT: begin
          dout       <= out_val;
          dout_valid <= 1'b1;
          state      <= ST_IDLE;
        end
        default: state <= ST_CLEAR;
      endcase
    end
  end

  // Delay line: zeroed entry by entry while clearing, written on accept.
  always_ff @(posedge clock_50) begin
    if (state == ST_CLEAR) begin
      dline[k] <= '0;
    end else if (accept) begin
      dline[wptr_next] <= din;
    end
  end

endmodule

// File: tb/tb_fir_tdm_param.sv
// tb_fir_tdm_param: directed bench for fir_tdm_param with a sample-history
// reference model checked every cycle, plus literal expected outputs.
module tb_fir_tdm_param;
  localparam int DATA_W = 16;
  localparam int COEF_W = 16;
  localparam int TAPS   = 57;
  localparam int FRAC   = 14;
  localparam int AW     = $clog2(TAPS);

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [DATA_W-1:0] din = '0;
  logic              din_valid = 1'b0;
  logic              din_ready;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              coef_we = 1'b0;
  logic [AW-1:0]     coef_addr = '0;
  logic [COEF_W-1:0] coef_wdata = '0;
  logic              busy;

  fir_tdm_param #(.DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS(TAPS), .FRAC(FRAC)) dut (
    .clock_50(clk), .reset(rst), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .dout(dout), .dout_valid(dout_valid),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: history of accepted samples (newest first) and the
  // coefficient set; timing follows the accept/compute/output schedule.
  longint            m_hist [TAPS];
  longint            m_coef [TAPS];
  int                clr_left = TAPS;
  int                busy_left = 0;
  logic [DATA_W-1:0] m_pending = '0;
  logic [DATA_W-1:0] m_dout = '0;
  logic              m_valid = 1'b0;
  int                m_accepts = 0;
  int                cap [$];

  function automatic logic [DATA_W-1:0] filt_out();
    longint sum = 0;
    longint sh;
    longint lim;
    for (int i = 0; i < TAPS; i++) sum += m_coef[i] * m_hist[i];
    sh  = sum >>> FRAC;
    lim = (longint'(1) <<< (DATA_W - 1));
`ifdef FIR_SAT_EN
    if (sh > lim - 1) sh = lim - 1;
    if (sh < -lim) sh = -lim;
`endif
    return sh[DATA_W-1:0];
  endfunction

  // Model update on every rising edge.
  always @(posedge clk) begin
    m_valid = 1'b0;
    if (rst) begin
      for (int i = 0; i < TAPS; i++) begin
        m_hist[i] = 0;
        m_coef[i] = 0;
      end
      clr_left  = TAPS;
      busy_left = 0;
      m_dout    = '0;
    end else if (clr_left > 0) begin
      clr_left--;
    end else if (busy_left > 0) begin
      busy_left--;
      if (busy_left == 0) begin
        m_valid = 1'b1;
        m_dout  = m_pending;
      end
    end else begin
      if (coef_we && int'(coef_addr) < TAPS) m_coef[coef_addr] = longint'($signed(coef_wdata));
      if (din_valid) begin
        for (int i = TAPS - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
        m_hist[0] = longint'($signed(din));
        m_pending = filt_out();
        busy_left = TAPS + 1;
        m_accepts++;
      end
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: all outputs against the model on every falling edge.
  always @(negedge clk) begin
    logic exp_ready;
    exp_ready = !rst && (clr_left == 0) && (busy_left == 0);
    check("din_ready", longint'(din_ready), longint'(exp_ready));
    check("busy", longint'(busy), longint'(!exp_ready));
    check("dout_valid", longint'(dout_valid), longint'(m_valid));
    check("dout", longint'(dout), longint'(m_dout));
    if (dout_valid) cap.push_back(int'($signed(dout)));
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int t = 0;
    while (!din_ready && t < 200) begin
      step();
      t++;
    end
    if (!din_ready) begin
      n_vec++;
      n_err++;
      $display("FAIL ready_timeout: din_ready still 0 after %0d cycles, expected 1", t);
    end
  endtask

  task automatic send_w(input int v, input logic we, input int a, input int cv);
    wait_ready();
    din        = DATA_W'(v);
    din_valid  = 1'b1;
    coef_we    = we;
    coef_addr  = AW'(a);
    coef_wdata = COEF_W'(cv);
    step();
    din_valid = 1'b0;
    coef_we   = 1'b0;
  endtask

  task automatic send(input int v);
    send_w(v, 1'b0, 0, 0);
  endtask

  task automatic write_coef(input int a, input int v);
    wait_ready();
    coef_we    = 1'b1;
    coef_addr  = AW'(a);
    coef_wdata = COEF_W'(v);
    step();
    coef_we = 1'b0;
  endtask

  function automatic int cap_at(input int idx);
    if (idx < 0 || idx >= cap.size()) return -99999;
    return cap[idx];
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int acc0;
    #1 rst = 1'b1;
    repeat (3) step();
    check("reset_dout", longint'(dout), 0);
    check("reset_dout_valid", longint'(dout_valid), 0);
    check("reset_din_ready", longint'(din_ready), 0);
    check("reset_busy", longint'(busy), 1);
    rst = 1'b0;

    // Impulse response with c[k] = k+1.
    for (int i = 0; i < TAPS; i++) write_coef(i, i + 1);
    base = cap.size();
    send(16384);
    for (int i = 0; i < TAPS; i++) send(0);
    wait_ready();
    for (int i = 0; i < TAPS; i++) check("impulse_tap", cap_at(base + i), i + 1);
    check("impulse_tail", cap_at(base + TAPS), 0);

    // Coefficient write while busy is dropped; in IDLE it takes effect.
    base = cap.size();
    send(16384);
    repeat (5) step();
    coef_we = 1'b1; coef_addr = AW'(3); coef_wdata = COEF_W'(100);
    repeat (10) step();
    coef_we = 1'b0;
    for (int i = 0; i < 3; i++) send(0);
    wait_ready();
    check("c3_unchanged", cap_at(base + 3), 4);
    write_coef(3, 100);
    write_coef(60, 999);
    send(16384);
    for (int i = 0; i < 3; i++) send(0);
    wait_ready();
    check("c3_written", cap_at(base + 7), 108);
    // Coefficient write coinciding with acceptance applies first.
    send_w(16384, 1'b1, 0, 7);
    wait_ready();
    check("coincident_write", cap_at(base + 8), 21);

    // Full-scale DC input with all coefficients at 1.0.
    for (int i = 0; i < TAPS; i++) write_coef(i, 16384);
    for (int i = 0; i < TAPS; i++) send(32767);
    wait_ready();
`ifdef FIR_SAT_EN
    check("dc_full_scale", cap_at(cap.size() - 1), 32767);
`else
    check("dc_full_scale", cap_at(cap.size() - 1), 32711);
`endif

    // Reset in the middle of MAC aborts the computation.
    base = cap.size();
    send(100);
    repeat (20) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_dout", longint'(dout), 0);
    wait_ready();
    check("abort_no_pulse", cap.size(), base);
    for (int i = 0; i < TAPS; i++) write_coef(i, 16384);
    send(16384);
    wait_ready();
    check("after_abort", cap_at(cap.size() - 1), 16384);

    // din_valid held high: one acceptance per TAPS+2 cycles.
    base = cap.size();
    acc0 = m_accepts;
    wait_ready();
    din_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      din = DATA_W'(i * 37 + 1);
      step();
    end
    din_valid = 1'b0;
    wait_ready();
    repeat (3) step();
    check("held_valid_accepts", m_accepts - acc0, 4);
    check("held_valid_outputs", cap.size() - base, 4);

    repeat (5) step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
